slide_debounce: RTL and testbench

Per-bit synchronizer and debouncer for the DE10-Lite slide switches. It sits directly upstream of the slide-switch PIO and drives that PIO's `in_port`, so the PIO's edge capture and IRQ logic only see one clean transition per physical switch flip. Each bit passes through a 2-flop synchronizer and a shared millisecond-scale tick prescaler. A per-bit stability counter then filters out bounce before the debounced value is registered onto the output.

---
 rtl/slide_debounce_if.sv | 19 +
 rtl/slide_debounce.sv | 98 +++++++++
 tb/tb_slide_debounce.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/slide_debounce_if.sv
// Switch-side bundle for slide_debounce: raw pins in, debounced level and tick strobe out.
// SLIDE_DEBOUNCE_CHANGED_EN adds the one-cycle 'changed' pulse to the bundle.
`timescale 1ns/1ps
interface slide_debounce_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic             tick;
`ifdef SLIDE_DEBOUNCE_CHANGED_EN
    logic             changed;

    modport master (output sw_raw, input sw_db, input tick, input changed);
    modport slave  (input sw_raw, output sw_db, output tick, output changed);
`else
    modport master (output sw_raw, input sw_db, input tick);
    modport slave  (input sw_raw, output sw_db, output tick);
`endif
endinterface

// File: rtl/slide_debounce.sv
// Per-bit 2-flop synchronizer plus tick-sampled stability filter for the slide switches.
// Optional feature macro: SLIDE_DEBOUNCE_CHANGED_EN (adds the registered 'changed' pulse).
`timescale 1ns/1ps
module slide_debounce #(
    parameter int WIDTH        = 10,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    slide_debounce_if.slave sw_if
);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [WIDTH-1:0]            sync1_q, sync1_d;
    logic [WIDTH-1:0]            sync2_q, sync2_d;
    logic [WIDTH-1:0]            sw_db_q, sw_db_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0]            pre_q, pre_d;
    logic                        tick_s;

    // Prescaler: free-running modulo-TICK_DIV count, tick on the last value.
    always_comb begin
        tick_s = (pre_q == PRE_LAST);
        if (tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Synchronizer next values.
    always_comb begin
        sync1_d = sw_if.sw_raw;
        sync2_d = sync1_q;
    end

    // Per-bit filter: any cycle back at the accepted level discards partial progress.
    always_comb begin
        sw_db_d = sw_db_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == sw_db_q[i]) begin
                cnt_d[i] = '0;
            end else if (!tick_s) begin
                cnt_d[i] = cnt_q[i];
            end else if (cnt_q[i] == CNT_LAST) begin
                sw_db_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sw_db_q <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sw_db_q <= sw_db_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
        end
    end

    assign sw_if.sw_db = sw_db_q;
    assign sw_if.tick  = tick_s;

`ifdef SLIDE_DEBOUNCE_CHANGED_EN
    logic changed_q, changed_d;

    // One pulse per tick edge on which any bit flips, however many flip.
    always_comb begin
        changed_d = |(sw_db_d ^ sw_db_q);
    end

    // Changed-pulse register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign sw_if.changed = changed_q;
`endif
endmodule

// File: tb/tb_slide_debounce.sv
// Self-checking bench for slide_debounce: directed scenarios plus randomized toggling,
// all compared every cycle against an arithmetic tick-window model.
`timescale 1ns/1ps
module tb_slide_debounce;
    localparam int W  = 10;
    localparam int D  = 4;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    slide_debounce_if #(.WIDTH(W)) sw_if ();

    slide_debounce #(.WIDTH(W), .TICK_DIV(D), .STABLE_TICKS(ST)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw_if   (sw_if)
    );

    always #5 clk = ~clk;

    // Model state: e = edges since reset release; a bit flips at a tick edge once the
    // number of tick edges inside its current unbroken mismatch window reaches ST.
    int           e;
    logic [W-1:0] m_db;
    logic         m_chg;
    logic [W-1:0] mis;
    int           start [W];
    logic [W-1:0] q [$];

    // Observation counters for directed scenarios.
    int           chg_pulses;
    int           bit3_rises;
    int           partial_seen;
    logic [W-1:0] prev_db;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic model_reset();
        e     = 0;
        m_db  = '0;
        m_chg = 1'b0;
        mis   = '0;
        q.delete();
        q.push_back('0);
        q.push_back('0);
    endtask

    task automatic compare();
        check("sw_db", 32'(sw_if.sw_db), 32'(m_db));
        check("tick", 32'(sw_if.tick), 32'(reset_n && ((e % D) == D - 1)));
`ifdef SLIDE_DEBOUNCE_CHANGED_EN
        check("changed", 32'(sw_if.changed), 32'(m_chg));
        if (sw_if.changed) chg_pulses++;
`endif
        if (sw_if.sw_db[3] && !prev_db[3]) bit3_rises++;
        if (sw_if.sw_db !== '0 && sw_if.sw_db !== 10'h2A5) partial_seen++;
        prev_db = sw_if.sw_db;
    endtask

    task automatic step();
        logic [W-1:0] raw_now;
        logic [W-1:0] s2;
        logic [W-1:0] flip;
        raw_now = sw_if.sw_raw;
        @(posedge clk);
        if (reset_n) begin
            e++;
            s2   = q[1];
            flip = '0;
            for (int i = 0; i < W; i++) begin
                if (s2[i] != m_db[i]) begin
                    if (!mis[i]) begin
                        mis[i]   = 1'b1;
                        start[i] = e;
                    end
                    if ((e % D) == 0 && (e / D - (start[i] - 1) / D) >= ST) begin
                        flip[i] = 1'b1;
                        mis[i]  = 1'b0;
                    end
                end else begin
                    mis[i] = 1'b0;
                end
            end
            m_db  = m_db ^ flip;
            m_chg = |flip;
            q.push_front(raw_now);
            void'(q.pop_back());
        end else begin
            model_reset();
        end
        #1;
        compare();
    endtask

    task automatic clear_obs();
        chg_pulses   = 0;
        bit3_rises   = 0;
        partial_seen = 0;
    endtask

    initial begin
        int e_fin;
        int first_hi;
        int f_edge;
        prev_db = '0;
        clear_obs();
        model_reset();

        // Reset held with all switches high.
        reset_n      = 1'b0;
        sw_if.sw_raw = 10'h3FF;
        #1;
        check("reset_db", 32'(sw_if.sw_db), 32'h0);
        repeat (3) step();
        check("reset_tick", 32'(sw_if.tick), 32'h0);

        // Single clean step on bit 0 at cycle 10; accepted on the tick edge at cycle 24.
        sw_if.sw_raw = '0;
        reset_n      = 1'b1;
        clear_obs();
        while (e < 30) begin
            step();
            if (e == 10) sw_if.sw_raw = 10'h001;
            if (e == 23) check("step_before", 32'(sw_if.sw_db), 32'h000);
            if (e == 24) check("step_at24", 32'(sw_if.sw_db), 32'h001);
        end
`ifdef SLIDE_DEBOUNCE_CHANGED_EN
        check("step_chg_once", 32'(chg_pulses), 32'd1);
`endif

        // Bounce on bit 3 with 5-cycle levels, then settle low.
        clear_obs();
        for (int k = 0; k < 8; k++) begin
            sw_if.sw_raw[3] = ~sw_if.sw_raw[3];
            repeat (5) step();
        end
        sw_if.sw_raw[3] = 1'b0;
        repeat (15) step();
        check("bounce_db", 32'(sw_if.sw_db), 32'h001);
        check("bounce_rise", 32'(bit3_rises), 32'd0);
`ifdef SLIDE_DEBOUNCE_CHANGED_EN
        check("bounce_chg", 32'(chg_pulses), 32'd0);
`endif

        // Six toggles at 3-cycle spacing, then hold high.
        clear_obs();
        for (int k = 0; k < 6; k++) begin
            sw_if.sw_raw[3] = ~sw_if.sw_raw[3];
            repeat (3) step();
        end
        sw_if.sw_raw[3] = 1'b1;
        e_fin    = e;
        first_hi = -1;
        repeat (20) begin
            step();
            if (first_hi < 0 && sw_if.sw_db[3]) first_hi = e;
        end
        check("settle_lat_min", 32'((first_hi - e_fin) >= 9), 32'd1);
        check("settle_lat_max", 32'((first_hi - e_fin) <= 14), 32'd1);
        check("settle_rises", 32'(bit3_rises), 32'd1);

        // Simultaneous multi-bit step from 0 to 10'h2A5.
        sw_if.sw_raw = '0;
        repeat (20) step();
        check("simul_zero", 32'(sw_if.sw_db), 32'h000);
        clear_obs();
        sw_if.sw_raw = 10'h2A5;
        repeat (20) step();
        check("simul_db", 32'(sw_if.sw_db), 32'h2A5);
        check("simul_partial", 32'(partial_seen), 32'd0);
`ifdef SLIDE_DEBOUNCE_CHANGED_EN
        check("simul_chg_once", 32'(chg_pulses), 32'd1);
`endif

        // Reset two cycles before a pending update to 10'h3FF.
        sw_if.sw_raw = 10'h3FF;
        f_edge = ((e + 3 + D - 1) / D) * D + (ST - 1) * D;
        while (e < f_edge - 2) step();
        check("pre_reset_db", 32'(sw_if.sw_db), 32'h2A5);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_db", 32'(sw_if.sw_db), 32'h000);
        repeat (2) step();
        reset_n = 1'b1;
        while (e < 14) begin
            step();
            if (e == 11) check("rst_rel_before", 32'(sw_if.sw_db), 32'h000);
            if (e == 12) check("rst_rel_at12", 32'(sw_if.sw_db), 32'h3FF);
        end

        // Randomized toggling checked against the model every cycle.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                sw_if.sw_raw = W'($urandom);
            end else begin
                sw_if.sw_raw = sw_if.sw_raw ^ W'(1 << $urandom_range(0, W - 1));
            end
            repeat ($urandom_range(1, 18)) step();
        end
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
